// File: rtl/fir_delay_multich.sv
// Time-multiplexed multi-channel delay line: each interleaved channel is delayed by DELAY_ACT frames
// through one shared sample RAM addressed as {channel, frame pointer}.
module fir_delay_multich #(
    parameter int BITWIDTH_DATA = 16,
    parameter int NUM_CH        = 4,
    parameter int MAX_DELAY     = 64,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int DW = $clog2(MAX_DELAY)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     EN,
    input  logic [DW-1:0]            DELAY_CFG,
    input  logic [BITWIDTH_DATA-1:0] DATA_IN,
    input  logic [CW-1:0]            CH_IN,
    input  logic                     VALID_IN,
    output logic                     READY_OUT,
    output logic [BITWIDTH_DATA-1:0] DATA_OUT,
    output logic [CW-1:0]            CH_OUT,
    output logic                     VALID_OUT,
    output logic [DW-1:0]            DELAY_ACT,
    output logic                     ERR_SEQ
);

    localparam int                DEPTH    = NUM_CH * MAX_DELAY;
    localparam logic [CW-1:0]     LAST_CH  = CW'(NUM_CH - 1);
    localparam logic [DW-1:0]     FILL_MAX = DW'(MAX_DELAY - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_ready;
    logic [DW-1:0]            r_ptr;
    logic [DW-1:0]            r_fill;
    logic [CW-1:0]            r_exp_ch;
    logic [DW-1:0]            r_delay_act;
    logic                     r_err_seq;
    logic                     r_vld_out;
    logic [BITWIDTH_DATA-1:0] r_data_out;
    logic [CW-1:0]            r_ch_out;

    logic [BITWIDTH_DATA-1:0] r_data;
    logic [CW-1:0]            r_ch;
    logic [BITWIDTH_DATA-1:0] r_ram_q;
    logic [BITWIDTH_DATA-1:0] r_ram [0:DEPTH-1];

    logic                     w_accept;
    logic                     w_seq_ok;
    logic                     w_frame_end;
    logic [DW-1:0]            w_rd_ptr;
    logic [CW+DW-1:0]         w_rd_addr;
    logic [CW+DW-1:0]         w_wr_addr;
    logic                     w_ram_we;
    logic                     w_ram_re;
    logic [BITWIDTH_DATA-1:0] w_out_data;

    assign READY_OUT = r_ready & EN;
    assign w_accept  = VALID_IN & READY_OUT;
    assign w_seq_ok  = (CH_IN == r_exp_ch);

    assign w_frame_end = (r_ch == LAST_CH);
    assign w_rd_ptr    = r_ptr - r_delay_act;
    assign w_rd_addr   = {r_ch, w_rd_ptr};
    assign w_wr_addr   = {r_ch, r_ptr};
    assign w_ram_re    = EN & (r_state == S_READ);
    assign w_ram_we    = EN & (r_state == S_WRITE);

    // Zero delay bypasses the RAM so no read-during-write ordering is needed
    always_comb begin
        w_out_data = r_ram_q;
        if (r_delay_act == '0) begin
            w_out_data = r_data;
        end else if (r_fill < r_delay_act) begin
            w_out_data = '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_seq_ok) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_ptr       <= '0;
            r_fill      <= '0;
            r_exp_ch    <= '0;
            r_delay_act <= '0;
            r_err_seq   <= 1'b0;
            r_vld_out   <= 1'b0;
            r_data_out  <= '0;
            r_ch_out    <= '0;
        end else if (!EN) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_ptr       <= '0;
            r_fill      <= '0;
            r_exp_ch    <= '0;
            r_delay_act <= '0;
            r_err_seq   <= 1'b0;
            r_vld_out   <= 1'b0;
            r_data_out  <= '0;
            r_ch_out    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= (w_state_nxt == S_IDLE);
            r_vld_out <= (r_state == S_WRITE);
            // Delay only changes between frames so every channel of a frame sees the same value
            if (r_state == S_IDLE && r_exp_ch == '0) begin
                r_delay_act <= DELAY_CFG;
            end
            if (w_accept && !w_seq_ok) begin
                r_err_seq <= 1'b1;
            end
            if (r_state == S_WRITE) begin
                r_data_out <= w_out_data;
                r_ch_out   <= r_ch;
                if (w_frame_end) begin
                    r_exp_ch <= '0;
                    r_ptr    <= r_ptr + 1'b1;
                    if (r_fill != FILL_MAX) begin
                        r_fill <= r_fill + 1'b1;
                    end
                end else begin
                    r_exp_ch <= r_exp_ch + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept && w_seq_ok) begin
            r_data <= DATA_IN;
            r_ch   <= CH_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_ram_we) begin
            r_ram[w_wr_addr] <= r_data;
        end
        if (w_ram_re) begin
            r_ram_q <= r_ram[w_rd_addr];
        end
    end

    assign DATA_OUT  = r_data_out;
    assign CH_OUT    = r_ch_out;
    assign VALID_OUT = r_vld_out;
    assign DELAY_ACT = r_delay_act;
    assign ERR_SEQ   = r_err_seq;

endmodule

// File: tb/tb_fir_delay_multich.sv
// Directed bench for fir_delay_multich: bypass, fixed delay, pointer wrap, delay change,
// channel-sequence errors, flush and asynchronous reset during a write.
module tb_fir_delay_multich;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        EN = 1'b1;
    logic [5:0]  DELAY_CFG = '0;
    logic [15:0] DATA_IN = '0;
    logic [1:0]  CH_IN = '0;
    logic        VALID_IN = 1'b0;
    logic        READY_OUT;
    logic [15:0] DATA_OUT;
    logic [1:0]  CH_OUT;
    logic        VALID_OUT;
    logic [5:0]  DELAY_ACT;
    logic        ERR_SEQ;

    int total = 0;
    int bad = 0;

    fir_delay_multich #(.BITWIDTH_DATA(16), .NUM_CH(4), .MAX_DELAY(64)) dut (
        .CLK(CLK), .nRST(nRST), .EN(EN), .DELAY_CFG(DELAY_CFG),
        .DATA_IN(DATA_IN), .CH_IN(CH_IN), .VALID_IN(VALID_IN), .READY_OUT(READY_OUT),
        .DATA_OUT(DATA_OUT), .CH_OUT(CH_OUT), .VALID_OUT(VALID_OUT),
        .DELAY_ACT(DELAY_ACT), .ERR_SEQ(ERR_SEQ)
    );

    always #5 CLK = ~CLK;

    task automatic do_reset();
        VALID_IN = 1'b0;
        EN = 1'b1;
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    // Offers one sample, waits for acceptance (bounded), then samples the outputs
    // one cycle (must be idle) and two cycles (must be the strobe) after the accept edge.
    task automatic send(input logic [1:0] ch, input logic [15:0] d, output bit acc,
                        output logic v_mid, output logic v_out,
                        output logic [15:0] dout, output logic [1:0] cout);
        CH_IN = ch;
        DATA_IN = d;
        VALID_IN = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            if (READY_OUT === 1'b1) acc = 1'b1;
            @(posedge CLK);
            #1;
        end
        VALID_IN = 1'b0;
        @(posedge CLK);
        #1;
        v_mid = VALID_OUT;
        @(posedge CLK);
        #1;
        v_out = VALID_OUT;
        dout = DATA_OUT;
        cout = CH_OUT;
    endtask

    task automatic test_reset();
        DELAY_CFG = 6'd5;
        EN = 1'b1;
        nRST = 1'b0;
        VALID_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        total++; if (READY_OUT !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", READY_OUT); end
        total++; if (VALID_OUT !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", VALID_OUT); end
        total++; if (DATA_OUT !== 16'h0) begin bad++; $display("FAIL reset_data got=%h want=0", DATA_OUT); end
        total++; if (CH_OUT !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d want=0", CH_OUT); end
        total++; if (ERR_SEQ !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", ERR_SEQ); end
        total++; if (DELAY_ACT !== 6'd0) begin bad++; $display("FAIL reset_delay got=%0d want=0", DELAY_ACT); end
        VALID_IN = 1'b0;
    endtask

    task automatic test_bypass();
        bit acc; logic vm, vo; logic [15:0] dout, exp; logic [1:0] cout, ch;
        DELAY_CFG = 6'd0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ch = 2'(i % 4);
            exp = 16'(i * 1234 - 3000);
            send(ch, exp, acc, vm, vo, dout, cout);
            total++;
            if (!acc || vm !== 1'b0 || vo !== 1'b1 || dout !== exp || cout !== ch) begin
                bad++;
                $display("FAIL bypass i=%0d got acc=%b vld=%b/%b data=%h ch=%0d want 1 0/1 data=%h ch=%0d",
                         i, acc, vm, vo, dout, cout, exp, ch);
            end
        end
        total++; if (DELAY_ACT !== 6'd0) begin bad++; $display("FAIL bypass_delay got=%0d want=0", DELAY_ACT); end
    endtask

    task automatic test_delay3();
        bit acc; logic vm, vo; logic [15:0] dout, exp; logic [1:0] cout;
        DELAY_CFG = 6'd3;
        do_reset();
        for (int n = 0; n < 6; n++) begin
            for (int c = 0; c < 4; c++) begin
                exp = (n < 3) ? 16'd0 : 16'(100 * (n - 3) + c);
                send(2'(c), 16'(100 * n + c), acc, vm, vo, dout, cout);
                total++;
                if (!acc || vm !== 1'b0 || vo !== 1'b1 || dout !== exp || cout !== 2'(c)) begin
                    bad++;
                    $display("FAIL delay3 f%0d ch%0d got acc=%b vld=%b/%b data=%0d ch=%0d want data=%0d",
                             n, c, acc, vm, vo, dout, cout, exp);
                end
            end
        end
        total++; if (DELAY_ACT !== 6'd3) begin bad++; $display("FAIL delay3_act got=%0d want=3", DELAY_ACT); end
    endtask

    task automatic test_wrap();
        bit acc; logic vm, vo; logic [15:0] dout, exp; logic [1:0] cout;
        DELAY_CFG = 6'd63;
        do_reset();
        for (int n = 0; n < 200; n++) begin
            for (int c = 0; c < 4; c++) begin
                exp = (n < 63) ? 16'd0 : 16'(4 * (n - 63) + c);
                send(2'(c), 16'(4 * n + c), acc, vm, vo, dout, cout);
                total++;
                if (!acc || vo !== 1'b1 || dout !== exp || cout !== 2'(c)) begin
                    bad++;
                    $display("FAIL wrap f%0d ch%0d got acc=%b vld=%b data=%0d ch=%0d want data=%0d",
                             n, c, acc, vo, dout, cout, exp);
                end
            end
        end
    endtask

    task automatic test_delay_change();
        bit acc; logic vm, vo; logic [15:0] dout, exp; logic [1:0] cout;
        int d;
        DELAY_CFG = 6'd2;
        do_reset();
        for (int n = 0; n < 15; n++) begin
            d = (n <= 10) ? 2 : 5;
            for (int c = 0; c < 4; c++) begin
                exp = (n < d) ? 16'd0 : 16'(100 * (n - d) + c);
                send(2'(c), 16'(100 * n + c), acc, vm, vo, dout, cout);
                total++;
                if (!acc || vo !== 1'b1 || dout !== exp || cout !== 2'(c)) begin
                    bad++;
                    $display("FAIL dchg f%0d ch%0d got acc=%b vld=%b data=%0d ch=%0d want data=%0d",
                             n, c, acc, vo, dout, cout, exp);
                end
                if (n == 10 && c == 1) DELAY_CFG = 6'd5;
                if (n == 10 && c == 2) begin
                    total++;
                    if (DELAY_ACT !== 6'd2) begin bad++; $display("FAIL dchg_mid got=%0d want=2", DELAY_ACT); end
                end
                if (n == 11 && c == 0) begin
                    total++;
                    if (DELAY_ACT !== 6'd5) begin bad++; $display("FAIL dchg_new got=%0d want=5", DELAY_ACT); end
                end
            end
        end
    endtask

    task automatic test_seq_err();
        bit acc; logic vm, vo; logic [15:0] dout; logic [1:0] cout;
        logic [1:0]  chs  [10] = '{0, 1, 2, 3, 0, 1, 3, 2, 3, 0};
        logic [15:0] dins [10] = '{10, 11, 12, 13, 20, 21, 23, 22, 23, 24};
        logic [15:0] exps [10] = '{0, 0, 0, 0, 10, 11, 0, 12, 13, 20};
        logic        vlds [10] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
        logic        errs [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        DELAY_CFG = 6'd1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(chs[i], dins[i], acc, vm, vo, dout, cout);
            total++;
            if (!acc || vo !== vlds[i] || ERR_SEQ !== errs[i] || (vlds[i] && (dout !== exps[i] || cout !== chs[i]))) begin
                bad++;
                $display("FAIL seq i=%0d got acc=%b vld=%b err=%b data=%0d ch=%0d want vld=%b err=%b data=%0d ch=%0d",
                         i, acc, vo, ERR_SEQ, dout, cout, vlds[i], errs[i], exps[i], chs[i]);
            end
        end
        EN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (ERR_SEQ !== 1'b0) begin bad++; $display("FAIL flush_err got=%b want=0", ERR_SEQ); end
        total++; if (READY_OUT !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", READY_OUT); end
        total++; if (DATA_OUT !== 16'd0 || VALID_OUT !== 1'b0) begin
            bad++; $display("FAIL flush_out got data=%0d vld=%b want 0 0", DATA_OUT, VALID_OUT);
        end
        total++; if (DELAY_ACT !== 6'd0) begin bad++; $display("FAIL flush_delay got=%0d want=0", DELAY_ACT); end
        EN = 1'b1;
        for (int n = 0; n < 2; n++) begin
            for (int c = 0; c < 4; c++) begin
                send(2'(c), 16'(30 + 10 * n + c), acc, vm, vo, dout, cout);
                total++;
                if (!acc || vo !== 1'b1 || ERR_SEQ !== 1'b0 || dout !== ((n == 0) ? 16'd0 : 16'(30 + c))) begin
                    bad++;
                    $display("FAIL post_flush f%0d ch%0d got acc=%b vld=%b err=%b data=%0d want data=%0d",
                             n, c, acc, vo, ERR_SEQ, dout, (n == 0) ? 0 : 30 + c);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc; logic vm, vo; logic [15:0] dout, exp; logic [1:0] cout;
        DELAY_CFG = 6'd2;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 4; c++) begin
                exp = (n < 2) ? 16'd0 : 16'(50 + 4 * (n - 2) + c);
                send(2'(c), 16'(50 + 4 * n + c), acc, vm, vo, dout, cout);
                total++;
                if (!acc || vo !== 1'b1 || dout !== exp) begin
                    bad++;
                    $display("FAIL pre_rst f%0d ch%0d got acc=%b vld=%b data=%0d want %0d", n, c, acc, vo, dout, exp);
                end
            end
        end
        CH_IN = 2'd0;
        DATA_IN = 16'd99;
        VALID_IN = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            if (READY_OUT === 1'b1) acc = 1'b1;
            @(posedge CLK);
            #1;
        end
        VALID_IN = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        total++;
        if (!acc || VALID_OUT !== 1'b0 || READY_OUT !== 1'b0 || DATA_OUT !== 16'd0 || DELAY_ACT !== 6'd0) begin
            bad++;
            $display("FAIL rst_write got acc=%b vld=%b rdy=%b data=%0d dly=%0d want 1 0 0 0 0",
                     acc, VALID_OUT, READY_OUT, DATA_OUT, DELAY_ACT);
        end
        @(posedge CLK);
        #1;
        total++; if (VALID_OUT !== 1'b0) begin bad++; $display("FAIL rst_write_vld got=%b want=0", VALID_OUT); end
        nRST = 1'b1;
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 4; c++) begin
                exp = (n < 2) ? 16'd0 : 16'(70 + c);
                send(2'(c), 16'(70 + 4 * n + c), acc, vm, vo, dout, cout);
                total++;
                if (!acc || vo !== 1'b1 || dout !== exp || cout !== 2'(c)) begin
                    bad++;
                    $display("FAIL post_rst f%0d ch%0d got acc=%b vld=%b data=%0d ch=%0d want %0d",
                             n, c, acc, vo, dout, cout, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_delay3();
        test_wrap();
        test_delay_change();
        test_seq_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
